// File: rtl/dmx_frame_engine.sv
// DMX512 universe engine: write-burst shadow buffer, boundary-atomic commit into an
// active buffer, and a break/MAB/slot serialiser for continuous or single-shot frames.
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | line at mark, waiting for enable or tx_go
// S_BREAK | line low for the break time
// S_MAB   | mark-after-break
// S_START | start bit of the current slot
// S_DATA  | eight data bits, LSB first
// S_STOP  | two stop bits; last slot ends the frame here
// S_IFG   | inter-frame mark in continuous mode
`timescale 1ns/1ps
module dmx_frame_engine #(
    parameter int NUM_SLOTS  = 512,
    parameter int WORD_BYTES = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 250000,
    parameter int BREAK_BITS = 22,
    parameter int MAB_BITS   = 2,
    parameter int IFG_BITS   = 4,
    localparam int AW = $clog2(NUM_SLOTS + 1),
    localparam int SW = $clog2(WORD_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AW-1:0]           wr_addr,
    input  logic [8*WORD_BYTES-1:0] wr_data,
    input  logic [SW-1:0]           wr_size,
    output logic                    wr_err,
    input  logic                    commit,
    output logic                    commit_pending,
    input  logic                    enable,
    input  logic                    tx_go,
    input  logic [AW-1:0]           frame_len,
    output logic                    dmx_tx,
    output logic                    tx_busy,
    output logic                    frame_done
);

    localparam int CPB      = CLK_HZ / BAUD;
    localparam int MAX_BITS = (BREAK_BITS > IFG_BITS) ?
                              ((BREAK_BITS > MAB_BITS) ? BREAK_BITS : MAB_BITS) :
                              ((IFG_BITS > MAB_BITS) ? IFG_BITS : MAB_BITS);
    localparam int TW       = $clog2(((MAX_BITS > 2) ? MAX_BITS : 2) * CPB);
    // Wide enough that wr_addr + wr_size never wraps.
    localparam int IW       = AW + SW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_BREAK, S_MAB, S_START, S_DATA, S_STOP, S_IFG
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [2:0]      bit_cnt, bit_nx;
    logic [AW-1:0]   slot, slot_nx;
    logic [AW-1:0]   len, len_nx;
    logic [7:0]      shift, shift_nx;
    logic            tx_q, tx_nx;
    logic            done_q, done_nx;
    logic            last_stop;
    logic            err_q;
    logic            pending;
    logic            copy_now;

    logic [7:0]      shadow [0:NUM_SLOTS];
    logic [7:0]      active [0:NUM_SLOTS];

    logic [IW-1:0]   addr_w, size_w, last_w;
    logic [IW-1:0]   byte_w [WORD_BYTES];
    logic [WORD_BYTES-1:0] byte_en;
    logic            size_bad, addr_bad, trunc, wr_fire, wr_ok;
    logic [AW-1:0]   len_clamped;

    assign len_clamped = (frame_len > AW'(NUM_SLOTS)) ? AW'(NUM_SLOTS) : frame_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            slot    <= '0;
            len     <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            bit_cnt <= bit_nx;
            slot    <= slot_nx;
            len     <= len_nx;
            shift   <= shift_nx;
            tx_q    <= tx_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        bit_nx    = bit_cnt;
        slot_nx   = slot;
        len_nx    = len;
        shift_nx  = shift;
        done_nx   = 1'b0;
        last_stop = 1'b0;
        if (state != S_IDLE && timer != '0)
            timer_nx = timer - TW'(1);
        unique case (state)
            S_IDLE: begin
                if (enable || tx_go) begin
                    state_nx = S_BREAK;
                    timer_nx = TW'(BREAK_BITS * CPB - 1);
                    len_nx   = len_clamped;
                end
            end
            S_BREAK: if (timer == '0) begin
                state_nx = S_MAB;
                timer_nx = TW'(MAB_BITS * CPB - 1);
            end
            S_MAB: if (timer == '0) begin
                state_nx = S_START;
                timer_nx = TW'(CPB - 1);
                slot_nx  = '0;
            end
            S_START: if (timer == '0) begin
                state_nx = S_DATA;
                timer_nx = TW'(CPB - 1);
                bit_nx   = '0;
                shift_nx = active[slot];
            end
            S_DATA: if (timer == '0) begin
                if (bit_cnt == 3'd7) begin
                    state_nx = S_STOP;
                    timer_nx = TW'(2 * CPB - 1);
                end else begin
                    timer_nx = TW'(CPB - 1);
                    bit_nx   = bit_cnt + 3'd1;
                    shift_nx = {1'b0, shift[7:1]};
                end
            end
            S_STOP: if (timer == '0) begin
                if (slot == len) begin
                    last_stop = 1'b1;
                    done_nx   = 1'b1;
                    if (enable) begin
                        state_nx = S_IFG;
                        timer_nx = TW'(IFG_BITS * CPB - 1);
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    state_nx = S_START;
                    timer_nx = TW'(CPB - 1);
                    slot_nx  = slot + AW'(1);
                end
            end
            S_IFG: if (timer == '0) begin
                if (enable) begin
                    state_nx = S_BREAK;
                    timer_nx = TW'(BREAK_BITS * CPB - 1);
                    len_nx   = len_clamped;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        unique case (state_nx)
            S_BREAK, S_START: tx_nx = 1'b0;
            S_DATA:           tx_nx = shift_nx[0];
            default:          tx_nx = 1'b1;
        endcase
    end

    // Copy only where no frame is reading the active buffer.
    assign copy_now = pending && (state == S_IDLE || state == S_IFG || last_stop);

    always_comb begin
        addr_w   = IW'(wr_addr);
        size_w   = IW'(wr_size);
        last_w   = addr_w + size_w - IW'(1);
        size_bad = (size_w == '0) || (size_w > IW'(WORD_BYTES));
        addr_bad = addr_w > IW'(NUM_SLOTS);
        trunc    = last_w > IW'(NUM_SLOTS);
        wr_fire  = wr_valid && wr_ready;
        wr_ok    = wr_fire && !size_bad && !addr_bad;
        for (int k = 0; k < WORD_BYTES; k++) begin
            byte_w[k]  = addr_w + IW'(k);
            byte_en[k] = wr_ok && (IW'(k) < size_w) && (byte_w[k] <= IW'(NUM_SLOTS));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= NUM_SLOTS; i++) shadow[i] <= '0;
        end else begin
            for (int k = 0; k < WORD_BYTES; k++)
                if (byte_en[k]) shadow[byte_w[k][AW-1:0]] <= wr_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= NUM_SLOTS; i++) active[i] <= '0;
        end else if (copy_now) begin
            active <= shadow;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (commit)        pending <= 1'b1;
            else if (copy_now) pending <= 1'b0;
            err_q <= wr_fire && (size_bad || addr_bad || trunc);
        end
    end

    assign wr_ready       = !copy_now;
    assign wr_err         = err_q;
    assign commit_pending = pending;
    assign dmx_tx         = tx_q;
    assign frame_done     = done_q;
    assign tx_busy        = (state != S_IDLE) && (state != S_IFG);

endmodule

// File: tb/tb_dmx_frame_engine.sv
// Directed bench for dmx_frame_engine at CPB=4: decodes the serial line and checks
// timing, slot data, write error handling, commit boundaries and mid-frame reset.
`timescale 1ns/1ps
module tb_dmx_frame_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  wr_size = '0;
    logic        wr_err;
    logic        commit = 1'b0;
    logic        commit_pending;
    logic        enable = 1'b0;
    logic        tx_go = 1'b0;
    logic [9:0]  frame_len = '0;
    logic        dmx_tx;
    logic        tx_busy;
    logic        frame_done;

    int n_vec = 0;
    int n_miscmp = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;
    int nlow = 0;
    int low_cyc = 0;
    logic busy_q = 1'b0;
    logic [7:0] rx_buf [0:512];

    dmx_frame_engine #(
        .NUM_SLOTS(512), .WORD_BYTES(4), .CLK_HZ(1000000), .BAUD(250000),
        .BREAK_BITS(22), .MAB_BITS(2), .IFG_BITS(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_size(wr_size), .wr_err(wr_err),
        .commit(commit), .commit_pending(commit_pending),
        .enable(enable), .tx_go(tx_go), .frame_len(frame_len),
        .dmx_tx(dmx_tx), .tx_busy(tx_busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_busy && !busy_q) t0 = cyc;
        busy_q = tx_busy;
        if (frame_done) done_cnt++;
        if (!wr_ready) begin
            nlow++;
            low_cyc = cyc;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, required finish before 80000 cycles");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int addr, input int size, input logic [31:0] data, input logic exp_err);
        wr_addr  = 10'(addr);
        wr_size  = 3'(size);
        wr_data  = data;
        wr_valid = 1'b1;
        check_eq("wr_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        check_eq($sformatf("wr_err_a%0d_s%0d", addr, size), wr_err, exp_err);
        @(negedge clk);
        check_eq("wr_err_one_cycle", wr_err, 0);
    endtask

    task automatic commit_idle();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check_eq("commit_pending_set", commit_pending, 1);
        check_eq("wr_ready_copy_cycle", wr_ready, 0);
        @(negedge clk);
        check_eq("commit_pending_clr", commit_pending, 0);
        check_eq("wr_ready_after_copy", wr_ready, 1);
    endtask

    task automatic pulse_go();
        tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
    endtask

    // Called on a negedge; returns on the mid-bit sample of the last stop bit.
    task automatic capture(input int nslots, output int gap);
        int t, lo, hi, ferr;
        logic [10:0] sh;
        t = 0;
        while (dmx_tx !== 1'b0 && t < 40000) begin
            @(negedge clk);
            t++;
        end
        gap = t;
        if (dmx_tx !== 1'b0) begin
            check_eq("break_seen", dmx_tx, 0);
            return;
        end
        lo = 0;
        while (dmx_tx === 1'b0 && lo < 1000) begin
            lo++;
            @(negedge clk);
        end
        check_eq("break_clocks", lo, 88);
        hi = 0;
        while (dmx_tx === 1'b1 && hi < 1000) begin
            hi++;
            @(negedge clk);
        end
        check_eq("mab_clocks", hi, 8);
        ferr = 0;
        sh = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s <= nslots; s++) begin
            for (int b = 0; b < 11; b++) begin
                sh[b] = dmx_tx;
                if (!(s == nslots && b == 10)) repeat (4) @(negedge clk);
            end
            if (sh[0] !== 1'b0 || sh[9] !== 1'b1 || sh[10] !== 1'b1) ferr++;
            rx_buf[s] = sh[8:1];
        end
        check_eq("framing_errors", ferr, 0);
    endtask

    task automatic check_slots(input string pfx, input int n, input logic [63:0] exp);
        for (int i = 0; i <= n; i++)
            check_eq($sformatf("%s_slot%0d", pfx, i), {24'h0, rx_buf[i]}, {24'h0, exp[8*i +: 8]});
    endtask

    task automatic wait_done(input int tmo, input int exp_dt);
        int t;
        t = 0;
        while (frame_done !== 1'b1 && t < tmo) begin
            @(negedge clk);
            t++;
        end
        check_eq("frame_done_seen", frame_done, 1);
        if (frame_done === 1'b1) begin
            check_eq("frame_done_time", cyc - t0, exp_dt);
            check_eq("tx_busy_at_done", tx_busy, 0);
        end
    endtask

    initial begin
        int g, nz, dc, dc0, t;

        repeat (2) @(negedge clk);
        check_eq("rst_dmx_tx", dmx_tx, 1);
        check_eq("rst_wr_ready", wr_ready, 1);
        check_eq("rst_wr_err", wr_err, 0);
        check_eq("rst_commit_pending", commit_pending, 0);
        check_eq("rst_tx_busy", tx_busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: four slots after a four-byte burst.
        wr(1, 4, 32'hDDCCBBAA, 1'b0);
        commit_idle();
        frame_len = 10'd4;
        pulse_go();
        capture(4, g);
        check_slots("basic", 4, 64'h0000_00DD_CCBB_AA00);
        wait_done(20, 316);
        check_eq("idle_line_after_frame", dmx_tx, 1);

        // Truncated and rejected writes, then a full clamped universe.
        wr(511, 4, 32'h44332211, 1'b1);
        wr(2, 0, 32'hFFFFFFFF, 1'b1);
        wr(1, 5, 32'hEEEEEEEE, 1'b1);
        wr(513, 1, 32'h00000077, 1'b1);
        commit_idle();
        frame_len = 10'd600;
        pulse_go();
        capture(512, g);
        check_slots("full", 4, 64'h0000_00DD_CCBB_AA00);
        check_eq("slot510", rx_buf[510], 8'h00);
        check_eq("slot511", rx_buf[511], 8'h11);
        check_eq("slot512", rx_buf[512], 8'h22);
        nz = 0;
        for (int s = 5; s < 510; s++) if (rx_buf[s] !== 8'h00) nz++;
        check_eq("untouched_slots_zero", nz, 0);
        wait_done(20, 22668);

        // Continuous mode with a commit landing mid-frame.
        repeat (5) @(negedge clk);
        frame_len = 10'd2;
        nlow = 0;
        enable = 1'b1;
        @(negedge clk);
        fork
            begin
                capture(2, g);
                check_slots("cont1", 2, 64'h0000_0000_00BB_AA00);
                capture(2, g);
                check_eq("ifg_gap", g, 18);
                check_slots("cont2", 2, 64'h0000_0000_00BB_5500);
            end
            begin
                repeat (100) @(negedge clk);
                wr(1, 1, 32'h00000055, 1'b0);
                commit = 1'b1;
                @(negedge clk);
                commit = 1'b0;
                check_eq("pending_mid_frame", commit_pending, 1);
                t = 0;
                while (frame_done !== 1'b1 && t < 400) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("cont_done_seen", frame_done, 1);
                check_eq("pending_clr_at_last_stop", commit_pending, 0);
                check_eq("wr_ready_low_cycles", nlow, 1);
                check_eq("wr_ready_low_at_last_stop", low_cyc, cyc - 1);
            end
        join

        // Drop enable mid-frame: this frame completes, no further frame.
        fork
            capture(2, g);
            begin
                repeat (60) @(negedge clk);
                enable = 1'b0;
            end
        join
        check_slots("cont3", 2, 64'h0000_0000_00BB_5500);
        wait_done(20, 228);
        @(negedge clk);
        dc = done_cnt;
        repeat (300) @(negedge clk);
        check_eq("no_frame_after_disable", done_cnt, dc);
        check_eq("idle_after_disable", tx_busy, 0);
        check_eq("line_mark_after_disable", dmx_tx, 1);

        // tx_go while busy is ignored.
        dc0 = done_cnt;
        frame_len = 10'd1;
        pulse_go();
        fork
            capture(1, g);
            begin
                repeat (30) @(negedge clk);
                pulse_go();
                repeat (100) @(negedge clk);
                pulse_go();
            end
        join
        check_slots("go_busy", 1, 64'h0000_0000_0000_5500);
        wait_done(20, 184);
        repeat (200) @(negedge clk);
        check_eq("single_frame_done", done_cnt - dc0, 1);
        check_eq("idle_after_single", tx_busy, 0);

        // Reset during data bit 0 of slot 3 (0xCC, bit 0 is low).
        frame_len = 10'd4;
        pulse_go();
        repeat (100) @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        repeat (132) @(negedge clk);
        check_eq("pre_rst_line_low", dmx_tx, 0);
        check_eq("pre_rst_pending", commit_pending, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_dmx_tx", dmx_tx, 1);
        check_eq("rst_mid_tx_busy", tx_busy, 0);
        check_eq("rst_mid_pending", commit_pending, 0);
        check_eq("rst_mid_frame_done", frame_done, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_go();
        capture(4, g);
        check_slots("post_rst", 4, 64'h0000_0000_0000_0000);
        wait_done(20, 316);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/dmx_frame_engine.md
Name: dmx_frame_engine

Overview:
- Parametrised DMX512 universe engine and successor to the single-universe byte store in the dmx module.
- Holds a shadow slot buffer written by the Avalon-side register logic in bursts of 1..WORD_BYTES bytes.
- On commit, copies the shadow buffer atomically into an active buffer at a frame boundary.
- Serialises the active buffer as DMX512 frames (break, MAB, start code, data slots), in continuous or single-shot mode.

Parameters:
NUM_SLOTS, 512, data slots per universe; slot 0 is the start code, so storage is NUM_SLOTS+1 bytes
WORD_BYTES, 4, maximum bytes per write burst
CLK_HZ, 50000000, clock frequency
BAUD, 250000, DMX bit rate; CPB = CLK_HZ/BAUD clocks per bit, integer, >= 2
BREAK_BITS, 22, break length in bit times (88 us at 250 kbaud)
MAB_BITS, 2, mark-after-break length in bit times
IFG_BITS, 4, mark time between frames in continuous mode

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  AW=$clog2(NUM_SLOTS+1)  first slot index
wr_data  in  8*WORD_BYTES  byte k lands at wr_addr+k
wr_size  in  $clog2(WORD_BYTES+1)  byte count
wr_err  out  1  one-cycle pulse on a rejected or truncated write
commit  in  1  pulse: request shadow->active copy
commit_pending  out  1  copy requested, not yet done
enable  in  1  continuous transmit mode
tx_go  in  1  single-shot frame trigger
frame_len  in  AW  data slots per frame, excluding start code
dmx_tx  out  1  serial line, idle high (mark)
tx_busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last stop bit

Behaviour:
Reset values:
- dmx_tx=1, wr_ready=1; wr_err, commit_pending, tx_busy, frame_done = 0.
- All shadow and active bytes are 0; FSM goes to IDLE.
- Reset mid-frame forces dmx_tx high asynchronously.

Writes:
- Accepted writes update the shadow buffer on the same edge; read-back is visible next cycle.
- Byte k goes to slot wr_addr+k from wr_data[8k+7:8k], for k < wr_size.
- wr_size == 0 or wr_size > WORD_BYTES: no change, wr_err pulses.
- wr_addr > NUM_SLOTS: no change, wr_err pulses.
- Partial overrun (wr_addr+wr_size-1 > NUM_SLOTS): in-range bytes are written, the rest are dropped, wr_err pulses.
- Address arithmetic must not wrap at 2^AW.
- wr_ready is low only in the copy cycle. Writes in that cycle are not accepted.

Commit:
- commit sets commit_pending.
- The copy occurs at a boundary: any cycle the FSM is in IDLE or IFG, or the cycle leaving the final STOP.
- All NUM_SLOTS+1 bytes are copied in one cycle, and commit_pending clears that cycle.
- Latency when IDLE: copy on the cycle after commit.
- A repeated commit while pending has no further effect.
- A commit in the copy cycle is re-latched.

FSM:
- IDLE: dmx_tx=1. Enter BREAK on enable, or on a tx_go pulse with enable low. Sample frame_len, clamped to NUM_SLOTS; tx_busy=1.
- BREAK: dmx_tx=0 for BREAK_BITS*CPB clocks.
- MAB: dmx_tx=1 for MAB_BITS*CPB clocks.
- Slot loop, for slot index s = 0..len:
  - START: 0 for 1 bit.
  - DATA: active[s] sent LSB first, 8 bits.
  - STOP: 1 for 2 bits.
- After the last STOP: frame_done pulses and tx_busy drops. Go to IFG if enable, else IDLE.
- IFG: dmx_tx=1 for IFG_BITS*CPB clocks, then BREAK if enable, else IDLE.
- frame_len = 0 sends the start code only.
- Each frame reads active data fixed for its whole duration, because copies occur only at boundaries.
- tx_go while busy is ignored.
- Deasserting enable mid-frame completes the current frame.
- Frame length in bit times: BREAK_BITS + MAB_BITS + 11*(len+1).

Test Plan:
- Sim with CLK_HZ=1000000, BAUD=250000 (CPB=4), NUM_SLOTS=512:
  - Reset, write addr 1, size 4, data 32'hDDCCBBAA, then commit, then tx_go, frame_len=4.
  - Required: 88 low clocks, 8 high, slot 0 = 0x00, slots 1..4 = AA,BB,CC,DD LSB-first with 2 stop bits.
  - Required: frame_done exactly 88+8+5*44 = 316 clocks after BREAK entry.
- Write addr 511, size 4, data 32'h44332211: slots 511=0x11 and 512=0x22; 0x33 and 0x44 are dropped; wr_err pulses once; no other slot changes.
- Write size 0, size 5, and addr 513: no shadow change, wr_err pulses each time; wr_ready stays high.
- enable=1, frame_len=2; write slot 1=0x55 and commit mid-frame.
  - Required: current frame still sends the old slot 1.
  - Required: commit_pending clears on the last-STOP exit; the next frame sends 0x55; wr_ready is low for exactly that cycle.
- Assert reset_n low during DATA of slot 3: dmx_tx=1, tx_busy=0, all buffers 0 immediately. After release, tx_go produces a full frame from BREAK.
- tx_go pulses while tx_busy: ignored, exactly one frame_done. Then drop enable mid-frame: the frame completes, then IDLE with no IFG.
